// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module rca4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end

    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: processes one nibble per cycle through a single 4-bit RCA.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high (outside reset)
// ST_RUN  | one nibble per edge, idx 0 .. NIBBLES-1, busy high
// ST_DONE | result held on S/Cout, out_valid high until out_ready
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    input  logic                      Cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] S,
    output logic                      Cout,
    output logic                      busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic               cout_q;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic               nib_c;
    logic               accept;
    logic               last;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN);
    assign S         = s_q;
    assign Cout      = cout_q;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    assign nib_a = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];

    rca4 u_rca4 (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry),
        .S    (nib_s),
        .Cout (nib_c)
    );

    // State register; reset overrides any in-flight or pending operation.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then fold one nibble per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            carry <= Cin;
            idx   <= '0;
            s_q   <= '0;
        end else if (state == ST_RUN) begin
            s_q[int'(idx)*NIBBLE_W +: NIBBLE_W] <= nib_s;
            carry <= nib_c;
            if (last) begin
                idx    <= '0;
                cout_q <= nib_c;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from accept until out_valid, bounded.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
    endtask

    // Accept a, b, cin; then drive na/nb/ncin while running; check result and release.
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] na, input logic [15:0] nb, input logic ncin,
                          input logic [15:0] exp_s, input logic exp_c);
        int n;
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        check({tag, "_in_ready_before"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        A = na; B = nb; Cin = ncin;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_run"}, in_ready, 0);
        wait_done(tag, n);
        check({tag, "_S"}, S, exp_s);
        check({tag, "_Cout"}, Cout, exp_c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_S_hold_idle"}, S, exp_s);
        check({tag, "_Cout_hold_idle"}, Cout, exp_c);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_S", S, 16'h0000);
        check("rst_Cout", Cout, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        run_op("zero",  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
        run_op("rip",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        run_op("mix",   16'h1234, 16'h4321, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h5556, 1'b0);
        run_op("msb",   16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b1);
        run_op("chg",   16'h00FF, 16'h0001, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // Back-pressure: hold DONE while new operands wait on in_valid.
        A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; in_valid = 1'b1;
        tick();
        A = 16'h2222; B = 16'h1111; Cin = 1'b0;
        wait_done("bp", n);
        check("bp_S", S, 16'h1000);
        check("bp_Cout", Cout, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_S", S, 16'h1000);
            check("bp_hold_Cout", Cout, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_busy", busy, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);
        tick();
        in_valid = 1'b0;
        check("bp_new_accept", busy, 1);
        wait_done("bp2", n);
        check("bp2_S", S, 16'h3333);
        check("bp2_Cout", Cout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second RUN cycle.
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rmid_busy1", busy, 1);
        tick();
        check("rmid_busy2", busy, 1);
        rst = 1'b1;
        tick();
        check("rmid_busy", busy, 0);
        check("rmid_out_valid", out_valid, 0);
        check("rmid_S", S, 16'h0000);
        check("rmid_Cout", Cout, 0);
        check("rmid_in_ready_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rmid_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        check("rmid_no_stale", seen, 0);
        check("rmid_S_after", S, 16'h0000);

        run_op("post",  16'h0001, 16'h0002, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (W = 4*NIBBLES).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-006 SHALL have port A, input, W bits: operand A.
REQ-007 SHALL have port B, input, W bits: operand B.
REQ-008 SHALL have port Cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port S, output, W bits: sum.
REQ-012 SHALL have port Cout, output, 1 bit: final carry-out.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) and not rst, and out_valid = (state==DONE).
REQ-016 SHALL, on an edge with in_valid and in_ready both high, latch A, B and Cin, clear nibble index idx to 0, clear S, and go to RUN.
REQ-017 SHALL, in each RUN cycle:
  - feed nibble idx of the latched A and B plus the carry register to one 4-bit ripple-carry adder;
  - write the adder's sum into nibble idx of S;
  - load the adder's carry-out into the carry register;
  - increment idx.
REQ-018 SHALL leave RUN for DONE on the edge that processes nibble NIBBLES-1; out_valid is therefore high after exactly NIBBLES edges following the accept edge.
REQ-019 SHALL present Cout = carry register value after the last nibble; S = (A+B+Cin) mod 2^W.
REQ-020 SHALL hold S, Cout and out_valid stable in DONE until an edge with out_ready high, then go to IDLE.
REQ-021 SHALL ignore in_valid, A, B and Cin outside IDLE; operands changing after acceptance do not affect the result.
REQ-022 SHALL keep S and Cout unchanged in IDLE after a completed operation, until the next acceptance.
REQ-023 SHALL sustain at most one operation per NIBBLES+2 cycles; no overlap of operations.

Reset
REQ-024 SHALL, on any edge with rst high, set state=IDLE, idx=0, carry=0, latched operands=0, S=0, Cout=0, out_valid=0, busy=0.
REQ-025 SHALL let reset override all other events, including in-flight RUN and pending DONE; an aborted operation is lost and never signalled.
REQ-026 SHALL hold in_ready=0 while rst is high and drive it to 1 on the first cycle after rst falls.

Structure
REQ-027 SHALL place the state enumeration and NIBBLE_W=4 constant in shared package nibble_serial_pkg.
REQ-028 SHALL instantiate the team's existing RCA4 4-bit ripple-carry adder (ports A, B, Cin, S, Cout) as the single sub-module; no other arithmetic.
REQ-029 SHALL select the nibble with idx-indexed slicing; idx width = clog2(NIBBLES), minimum 1.

Verification (NIBBLES=4)
REQ-030 SHALL cover zero operands: A=0x0000, B=0x0000, Cin=0 -> S=0x0000, Cout=0, out_valid high 4 edges after accept.
REQ-031 SHALL cover full carry ripple: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1.
REQ-032 SHALL cover mixed operands with carry-in: A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0. Also A=0x8000, B=0x8000, Cin=1 -> S=0x0001, Cout=1.
REQ-033 SHALL cover back-pressure: out_ready low for 5 cycles in DONE with in_valid held high and new operands applied -> S, Cout and out_valid stable, in_ready=0, no acceptance; out_ready high -> IDLE next edge, then the new operands are accepted.
REQ-034 SHALL cover reset mid-operation: rst high for one edge during the 2nd RUN cycle -> next cycle state IDLE, S=0, Cout=0, out_valid=0, busy=0; in_ready=1 after rst falls; no stale result appears.
REQ-035 SHALL cover operand change after accept: accept A=0x00FF, B=0x0001, then change A to 0xFFFF during RUN -> S=0x0100, Cout=0.
